// File: rtl/riscv_multicycle_ctrl.sv
// Multicycle control FSM for an RV32I subset (lw, sw, add, xor, sll, addi, bne).
// Shares one memory port between fetch and data, counts retired instructions, halts on illegal.
module riscv_multicycle_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic        alu_zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_sel,
    output logic        mem_we,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_src,
    output logic        reg_we,
    output logic        mem_to_reg,
    output logic        alu_src,
    output logic [1:0]  alu_op,
    output logic        illegal,
    output logic [31:0] instret,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        C_LW, C_SW, C_RTYPE, C_ADDI, C_BNE, C_BAD
    } iclass_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    state_t      state_q, state_d;
    iclass_t     cls_q, cls_d, dec_cls;
    logic        illegal_q, illegal_d;
    logic [31:0] instret_q, instret_d;
    logic        retire;

    // Only the exact encodings below are supported; everything else halts.
    always_comb begin
        dec_cls = C_BAD;
        case (opcode)
            7'b0000011: if (funct3 == 3'b010) dec_cls = C_LW;
            7'b0100011: if (funct3 == 3'b010) dec_cls = C_SW;
            7'b0110011: begin
                if (funct7 == 7'b0000000 &&
                    (funct3 == 3'b000 || funct3 == 3'b100 || funct3 == 3'b001))
                    dec_cls = C_RTYPE;
            end
            7'b0010011: if (funct3 == 3'b000) dec_cls = C_ADDI;
            7'b1100011: if (funct3 == 3'b001) dec_cls = C_BNE;
            default:    dec_cls = C_BAD;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cls_d      = cls_q;
        illegal_d  = illegal_q;
        retire     = 1'b0;
        mem_req    = 1'b0;
        mem_sel    = 1'b0;
        mem_we     = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 1'b0;
        reg_we     = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        alu_op     = ALU_ADD;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                cls_d = dec_cls;
                if (dec_cls == C_BAD) begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (cls_q)
                    C_LW, C_SW: begin
                        alu_src = 1'b1;
                        state_d = S_MEM;
                    end
                    C_RTYPE: begin
                        alu_op  = ALU_FUNCT;
                        state_d = S_WB;
                    end
                    C_ADDI: begin
                        alu_src = 1'b1;
                        alu_op  = ALU_FUNCT;
                        state_d = S_WB;
                    end
                    C_BNE: begin
                        alu_op = ALU_SUB;
                        if (!alu_zero) begin
                            pc_we  = 1'b1;
                            pc_src = 1'b1;
                        end
                        retire = 1'b1;
                    end
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_HALT;
                    end
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_sel = 1'b1;
                alu_src = 1'b1;
                mem_we  = (cls_q == C_SW);
                if (mem_ready) begin
                    if (cls_q == C_SW) retire = 1'b1;
                    else               state_d = S_WB;
                end
            end
            S_WB: begin
                reg_we     = 1'b1;
                mem_to_reg = (cls_q == C_LW);
                retire     = 1'b1;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: state_d = S_IDLE;
        endcase
        // run is only honoured at an instruction boundary.
        if (retire) state_d = run ? S_FETCH : S_IDLE;
    end

    assign instret_d = retire ? instret_q + 32'd1 : instret_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cls_q     <= C_BAD;
            illegal_q <= 1'b0;
            instret_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            illegal_q <= illegal_d;
            instret_q <= instret_d;
        end
    end

    assign illegal   = illegal_q;
    assign instret   = instret_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Bench for riscv_multicycle_ctrl: per-instruction cycle timelines built from the
// instruction class and memory latency are compared against the strobes each cycle.
module tb_riscv_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic [6:0]  funct7 = '0;
    logic        alu_zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_sel, mem_we, ir_we, pc_we, pc_src;
    logic        reg_we, mem_to_reg, alu_src, illegal;
    logic [1:0]  alu_op;
    logic [31:0] instret;
    logic [2:0]  dbg_state;
    logic [10:0] obs;

    riscv_multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .funct3(funct3),
        .funct7(funct7), .alu_zero(alu_zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_sel(mem_sel), .mem_we(mem_we), .ir_we(ir_we),
        .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we), .mem_to_reg(mem_to_reg),
        .alu_src(alu_src), .alu_op(alu_op), .illegal(illegal), .instret(instret),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    assign obs = {mem_req, mem_sel, mem_we, ir_we, pc_we, pc_src,
                  reg_we, mem_to_reg, alu_src, alu_op};

    localparam logic [10:0] REQ  = 11'h400;
    localparam logic [10:0] SEL  = 11'h200;
    localparam logic [10:0] MWE  = 11'h100;
    localparam logic [10:0] IRW  = 11'h080;
    localparam logic [10:0] PCW  = 11'h040;
    localparam logic [10:0] PCS  = 11'h020;
    localparam logic [10:0] REGW = 11'h010;
    localparam logic [10:0] M2R  = 11'h008;
    localparam logic [10:0] SRC  = 11'h004;
    localparam logic [10:0] OP   = 11'h003;
    localparam logic [10:0] OP01 = 11'h001;
    localparam logic [10:0] OP10 = 11'h002;
    localparam logic [10:0] STB  = 11'h5D0;
    localparam logic [10:0] ALL  = 11'h7FF;

    typedef struct {
        logic        run;
        logic        rdy;
        logic        zero;
        logic [31:0] instr;
        logic [10:0] exp;
        logic [10:0] care;
        logic        retire;
        logic        ill;
    } step_t;

    step_t       plan_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] model_instret = '0;
    logic        plan_ill = 1'b0;
    logic        plan_running = 1'b0;

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s (vector %0d): observed %h expected %h", tag, vectors, o, e);
        end
    endtask

    // 0 lw, 1 sw, 2 R-type, 3 addi, 4 bne, 5 unsupported
    function automatic int classify(input logic [31:0] ins);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        if (op == 7'b0000011 && f3 == 3'b010) return 0;
        if (op == 7'b0100011 && f3 == 3'b010) return 1;
        if (op == 7'b0110011 && f7 == 7'd0 && (f3 == 3'b000 || f3 == 3'b100 || f3 == 3'b001)) return 2;
        if (op == 7'b0010011 && f3 == 3'b000) return 3;
        if (op == 7'b1100011 && f3 == 3'b001) return 4;
        return 5;
    endfunction

    function automatic logic [31:0] rand_instr(input int c);
        logic [31:0] r;
        logic [2:0]  f3;
        int          k;
        r = $urandom;
        k = $urandom_range(0, 2);
        f3 = (k == 0) ? 3'b000 : (k == 1) ? 3'b100 : 3'b001;
        case (c)
            0:       rand_instr = {r[31:15], 3'b010, r[11:7], 7'b0000011};
            1:       rand_instr = {r[31:15], 3'b010, r[11:7], 7'b0100011};
            2:       rand_instr = {7'b0000000, r[24:15], f3, r[11:7], 7'b0110011};
            3:       rand_instr = {r[31:15], 3'b000, r[11:7], 7'b0010011};
            default: rand_instr = {r[31:15], 3'b001, r[11:7], 7'b1100011};
        endcase
    endfunction

    task automatic push(input logic r, input logic rdy, input logic z, input logic [31:0] ins,
                        input logic [10:0] e, input logic [10:0] c, input logic ret);
        step_t s;
        s.run = r; s.rdy = rdy; s.zero = z; s.instr = ins;
        s.exp = e; s.care = c; s.retire = ret; s.ill = plan_ill;
        plan_q.push_back(s);
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // n idle cycles with run low, then one idle cycle with run high
    task automatic plan_idle(input int n);
        for (int i = 0; i < n; i++) push(1'b0, rbit(), rbit(), 32'd0, 11'd0, ALL, 1'b0);
        push(1'b1, rbit(), rbit(), 32'd0, 11'd0, ALL, 1'b0);
    endtask

    task automatic plan_halt(input int n);
        for (int i = 0; i < n; i++) push(rbit(), rbit(), rbit(), $urandom, 11'd0, ALL, 1'b0);
    endtask

    task automatic plan_instr(input logic [31:0] ins, input int wf, input int wd,
                              input logic z, input logic run_after);
        int c;
        c = classify(ins);
        if (!plan_running) plan_idle($urandom_range(0, 2));
        plan_running = run_after;
        for (int i = 0; i < wf; i++) push(run_after, 1'b0, z, ins, REQ, STB | SEL, 1'b0);
        push(run_after, 1'b1, z, ins, REQ | IRW | PCW, STB | SEL | PCS, 1'b0);
        push(run_after, rbit(), z, ins, 11'd0, STB, 1'b0);
        if (c == 5) begin
            plan_ill = 1'b1;
            return;
        end
        case (c)
            0, 1: begin
                push(run_after, rbit(), z, ins, SRC, STB | SRC | OP, 1'b0);
                for (int i = 0; i <= wd; i++)
                    push(run_after, (i == wd), z, ins, REQ | SEL | SRC | ((c == 1) ? MWE : 11'd0),
                         STB | SEL | SRC | OP, (c == 1) && (i == wd));
                if (c == 0) push(run_after, rbit(), z, ins, REGW | M2R, STB | M2R, 1'b1);
            end
            2, 3: begin
                push(run_after, rbit(), z, ins, OP10 | ((c == 3) ? SRC : 11'd0), STB | SRC | OP, 1'b0);
                push(run_after, rbit(), z, ins, REGW, STB | M2R, 1'b1);
            end
            default: begin
                push(run_after, rbit(), z, ins, OP01 | (z ? 11'd0 : (PCW | PCS)),
                     STB | SRC | OP | PCS, 1'b1);
            end
        endcase
    endtask

    // Called just after a rising edge; runs until only `keep` steps remain.
    task automatic execute_plan(input int keep);
        step_t s;
        while (plan_q.size() > keep) begin
            s = plan_q.pop_front();
            run = s.run; mem_ready = s.rdy; alu_zero = s.zero;
            opcode = s.instr[6:0]; funct3 = s.instr[14:12]; funct7 = s.instr[31:25];
            @(negedge clk);
            check("strobes", {21'd0, obs & s.care}, {21'd0, s.exp & s.care});
            check("instret", instret, model_instret);
            check("illegal", {31'd0, illegal}, {31'd0, s.ill});
            @(posedge clk);
            #1;
            if (s.retire) model_instret = model_instret + 32'd1;
        end
    endtask

    task automatic do_reset_now();
        rst_n = 1'b0;
        run = 1'b0;
        #1;
        check("reset_strobes", {21'd0, obs}, 32'd0);
        check("reset_instret", instret, 32'd0);
        check("reset_illegal", {31'd0, illegal}, 32'd0);
        plan_q.delete();
        model_instret = '0;
        plan_ill = 1'b0;
        plan_running = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int c;
        #3;
        check("por_strobes", {21'd0, obs}, 32'd0);
        check("por_instret", instret, 32'd0);
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // directed instructions from the plan
        plan_instr(32'h00208233, 0, 0, 1'b0, 1'b1);
        plan_instr(32'h00402083, 0, 2, 1'b0, 1'b1);
        plan_instr(32'h0020A023, 1, 0, 1'b0, 1'b1);
        plan_instr(32'h00209063, 0, 0, 1'b0, 1'b1);
        plan_instr(32'h00209063, 0, 0, 1'b1, 1'b0);
        plan_instr(32'h00208233, 2, 1, 1'b1, 1'b0);
        execute_plan(0);

        // randomized legal mix with random wait states, branch outcome and run
        for (int n = 0; n < 40; n++) begin
            c = $urandom_range(0, 4);
            plan_instr(rand_instr(c), $urandom_range(0, 2), $urandom_range(0, 3), rbit(),
                       (n == 39) ? 1'b0 : ($urandom_range(0, 3) != 0));
        end
        push(1'b0, rbit(), rbit(), 32'd0, 11'd0, ALL, 1'b0);
        execute_plan(0);

        // counter rollover: preload in IDLE, retire one add
        force dut.instret_q = 32'hFFFF_FFFF;
        #1 release dut.instret_q;
        model_instret = 32'hFFFF_FFFF;
        plan_instr(32'h00208233, 0, 0, 1'b0, 1'b0);
        push(1'b0, rbit(), rbit(), 32'd0, 11'd0, ALL, 1'b0);
        execute_plan(0);
        check("instret_wrapped", instret, 32'd0);

        // illegal instruction halts stickily, even with run high
        plan_instr(32'hFFFF_FFFF, 1, 0, 1'b0, 1'b1);
        plan_halt(6);
        execute_plan(0);
        #2;
        do_reset_now();

        // near-miss encoding (sub) is also unsupported
        plan_instr(32'h40208233, 0, 0, 1'b0, 1'b1);
        plan_halt(3);
        execute_plan(0);
        #2;
        do_reset_now();

        // reset asserted while lw waits in MEM
        plan_instr(32'h00208233, 0, 0, 1'b0, 1'b1);
        plan_instr(32'h00402083, 0, 5, 1'b0, 1'b1);
        execute_plan(6);
        run = 1'b1;
        mem_ready = 1'b0;
        check("mem_req_before_reset", {31'd0, mem_req}, 32'd1);
        #2;
        do_reset_now();

        // normal operation after reset
        plan_instr(32'h0020A023, 0, 1, 1'b0, 1'b0);
        push(1'b0, rbit(), rbit(), 32'd0, 11'd0, ALL, 1'b0);
        execute_plan(0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
